// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Transmit-side byte queue and frame tracker for a UART. Bytes written by the
//   host are queued (single-entry THR or circular FIFO) and presented to the
//   transmitter on tx_data. A small FSM tracks whether a frame is in flight so
//   that temt reports a fully drained transmitter.
//
// Build option
//   UART_TX_FIFO_EN : when defined, FIFO_DEPTH-entry storage is built and
//                     fifo_en selects FIFO (1) or single-entry THR (0) mode.
//                     When undefined, only the single THR exists and fifo_en
//                     is ignored.
//
// Parameters
//   FIFO_DEPTH     FIFO entries, power of two, 2..64
//
// Ports
//   pclk           clock
//   presetn        asynchronous reset, active-low
//   utrst          synchronous transmitter soft reset (flush + FSM to IDLE)
//   thr_wr         write strobe, wdata sampled when high
//   wdata[7:0]     write data
//   fifo_en        FIFO mode select (a change flushes the queue)
//   tx_fifo_clr    synchronous queue flush
//   tsr_load       transmitter load pulse, pops the head entry
//   transmit_edge  baud tick from the transmit divider
//   shift_cnt_eq   transmitter frame-complete compare
//   thre           queue empty
//   tx_data[7:0]   head-of-queue byte, 8'h00 when empty
//   temt           queue empty and no frame in flight
//   tx_level[6:0]  queued byte count
//   tx_overrun     one-cycle pulse when a write is dropped
//   thre_int       one-cycle pulse when thre rises
//
// FSM states
//   state | meaning
//   IDLE  | no frame in flight
//   BUSY  | transmitter shifting a frame
module uart_tx_scheduler #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       utrst,
    input  logic       thr_wr,
    input  logic [7:0] wdata,
    input  logic       fifo_en,
    input  logic       tx_fifo_clr,
    input  logic       tsr_load,
    input  logic       transmit_edge,
    input  logic       shift_cnt_eq,
    output logic       thre,
    output logic [7:0] tx_data,
    output logic       temt,
    output logic [6:0] tx_level,
    output logic       tx_overrun,
    output logic       thre_int
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nx;
    logic [CW-1:0]   depth_eff;
    logic            mode_chg;
    logic            flush;
    logic            load_ok;
    logic            full;
    logic            push;
    logic            pop;
    logic            thre_nx;

`ifdef UART_TX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          mode_q;

    // mode_q holds the mode the current queue contents were written under;
    // any difference from fifo_en means the mode just changed.
    assign mode_chg  = fifo_en ^ mode_q;
    assign depth_eff = mode_q ? CW'(FIFO_DEPTH) : CW'(1);

    // In THR mode the pointers stay pinned at entry 0.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mode_q <= 1'b0;
        end else begin
            mode_q <= fifo_en;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= mode_q ? wr_ptr + PW'(1) : '0;
                if (pop)  rd_ptr <= mode_q ? rd_ptr + PW'(1) : '0;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign tx_data = thre ? 8'h00 : mem[rd_ptr];
`else
    logic [7:0] thr_q;
    logic       unused_fifo_en;

    assign unused_fifo_en = fifo_en;
    assign mode_chg       = 1'b0;
    assign depth_eff      = CW'(1);

    always_ff @(posedge pclk) begin
        if (push) thr_q <= wdata;
    end

    assign tx_data = thre ? 8'h00 : thr_q;
`endif

    assign flush   = utrst | tx_fifo_clr | mode_chg;
    // A load against an empty queue is a no-op for both queue and FSM.
    assign load_ok = tsr_load & (count != '0);
    assign full    = (count == depth_eff);
    assign pop     = ~flush & load_ok;
    // A same-cycle pop frees the slot, so a write into a full queue still lands.
    assign push    = ~flush & thr_wr & (~full | load_ok);

    assign count_nx = flush ? '0 : count + CW'(push) - CW'(pop);
    assign thre_nx  = (count_nx == '0);

    // Flushes from tx_fifo_clr or a mode change leave the FSM alone; only
    // utrst forces it back to IDLE.
    always_comb begin
        state_nx = state;
        if (utrst) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (load_ok) state_nx = BUSY;
                BUSY: begin
                    if (load_ok)
                        state_nx = BUSY;
                    else if (transmit_edge && shift_cnt_eq && !tsr_load)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            count      <= '0;
            thre       <= 1'b1;
            temt       <= 1'b1;
            tx_overrun <= 1'b0;
            thre_int   <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            thre       <= thre_nx;
            temt       <= thre_nx & (state_nx == IDLE);
            tx_overrun <= ~flush & thr_wr & ~push;
            thre_int   <= thre_nx & ~thre;
        end
    end

    // count never exceeds FIFO_DEPTH, so the level needs no saturation logic.
    assign tx_level = 7'(count);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    localparam int DEPTH = 16;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       utrst = 1'b0;
    logic       thr_wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       fifo_en = 1'b0;
    logic       tx_fifo_clr = 1'b0;
    logic       tsr_load = 1'b0;
    logic       transmit_edge = 1'b0;
    logic       shift_cnt_eq = 1'b0;
    logic       thre;
    logic [7:0] tx_data;
    logic       temt;
    logic [6:0] tx_level;
    logic       tx_overrun;
    logic       thre_int;

    int checks = 0;
    int failures = 0;

    // Reference model: a byte queue plus a frame-in-flight flag.
    logic [7:0] mq[$];
    bit         m_busy = 1'b0;
    bit         m_mode = 1'b0;
    bit         m_ov = 1'b0;
    bit         m_ti = 1'b0;

    uart_tx_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .utrst         (utrst),
        .thr_wr        (thr_wr),
        .wdata         (wdata),
        .fifo_en       (fifo_en),
        .tx_fifo_clr   (tx_fifo_clr),
        .tsr_load      (tsr_load),
        .transmit_edge (transmit_edge),
        .shift_cnt_eq  (shift_cnt_eq),
        .thre          (thre),
        .tx_data       (tx_data),
        .temt          (temt),
        .tx_level      (tx_level),
        .tx_overrun    (tx_overrun),
        .thre_int      (thre_int)
    );

    always #5 pclk = ~pclk;

    function automatic int model_depth();
`ifdef UART_TX_FIFO_EN
        return m_mode ? DEPTH : 1;
`else
        return 1;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b0;
        m_mode = 1'b0;
        m_ov   = 1'b0;
        m_ti   = 1'b0;
    endtask

    task automatic model_step();
        bit flush;
        bit vload;
        bit was_empty;
        int n0;
        int dep;
        n0        = mq.size();
        was_empty = (n0 == 0);
        vload     = tsr_load && (n0 > 0);
        dep       = model_depth();
`ifdef UART_TX_FIFO_EN
        flush  = utrst || tx_fifo_clr || (fifo_en != m_mode);
        m_mode = fifo_en;
`else
        flush  = utrst || tx_fifo_clr;
`endif
        if (utrst) m_busy = 1'b0;
        else if (vload) m_busy = 1'b1;
        else if (m_busy && transmit_edge && shift_cnt_eq && !tsr_load) m_busy = 1'b0;
        m_ov = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            if (vload) void'(mq.pop_front());
            if (thr_wr) begin
                if (n0 < dep || vload) mq.push_back(wdata);
                else m_ov = 1'b1;
            end
        end
        m_ti = !was_empty && (mq.size() == 0);
    endtask

    task automatic tick();
        @(posedge pclk);
        model_step();
        #1;
    endtask

    task automatic cyc(input bit wr, input logic [7:0] d, input bit ld,
                       input bit te, input bit eq, input bit clr, input bit ut);
        thr_wr        = wr;
        wdata         = d;
        tsr_load      = ld;
        transmit_edge = te;
        shift_cnt_eq  = eq;
        tx_fifo_clr   = clr;
        utrst         = ut;
        tick();
        thr_wr        = 1'b0;
        tsr_load      = 1'b0;
        transmit_edge = 1'b0;
        shift_cnt_eq  = 1'b0;
        tx_fifo_clr   = 1'b0;
        utrst         = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        #12;
        checks++; if (thre !== 1'b1) begin failures++; $display("FAIL reset_thre got %b want 1", thre); end
        checks++; if (temt !== 1'b1) begin failures++; $display("FAIL reset_temt got %b want 1", temt); end
        checks++; if (tx_level !== 7'd0) begin failures++; $display("FAIL reset_level got %0d want 0", tx_level); end
        checks++; if (tx_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got %b want 0", tx_overrun); end
        checks++; if (thre_int !== 1'b0) begin failures++; $display("FAIL reset_thre_int got %b want 0", thre_int); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        model_reset();
        presetn = 1'b1;
    endtask

    task automatic test_thr_mode();
        fifo_en = 1'b0;
        cyc(1, 8'hA5, 0, 0, 0, 0, 0);
        checks++; if (thre !== 1'b0) begin failures++; $display("FAIL thr_wr_thre got %b want 0", thre); end
        checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL thr_wr_data got %h want a5", tx_data); end
        checks++; if (tx_level !== 7'd1) begin failures++; $display("FAIL thr_wr_level got %0d want 1", tx_level); end
        cyc(1, 8'h22, 0, 0, 0, 0, 0);
        checks++; if (tx_overrun !== 1'b1) begin failures++; $display("FAIL thr_overrun got %b want 1", tx_overrun); end
        checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL thr_overrun_data got %h want a5", tx_data); end
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        checks++; if (tx_overrun !== 1'b0) begin failures++; $display("FAIL thr_overrun_end got %b want 0", tx_overrun); end
        checks++; if (thre !== 1'b1) begin failures++; $display("FAIL thr_pop_thre got %b want 1", thre); end
        checks++; if (thre_int !== 1'b1) begin failures++; $display("FAIL thr_pop_thre_int got %b want 1", thre_int); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL thr_empty_data got %h want 00", tx_data); end
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        checks++; if (thre_int !== 1'b0) begin failures++; $display("FAIL thr_thre_int_once got %b want 0", thre_int); end
        cyc(0, 8'h00, 0, 1, 1, 0, 0);
    endtask

    task automatic test_temt();
        cyc(1, 8'h3C, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        checks++; if (temt !== 1'b0) begin failures++; $display("FAIL temt_busy got %b want 0", temt); end
        cyc(0, 8'h00, 0, 1, 1, 0, 0);
        checks++; if (temt !== 1'b1) begin failures++; $display("FAIL temt_done_empty got %b want 1", temt); end
        cyc(1, 8'h41, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        cyc(1, 8'h42, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 1, 1, 0, 0);
        checks++; if (temt !== 1'b0) begin failures++; $display("FAIL temt_done_nonempty got %b want 0", temt); end
        checks++; if (tx_data !== 8'h42) begin failures++; $display("FAIL temt_pending_data got %h want 42", tx_data); end
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 1, 1, 0, 0);
        checks++; if (temt !== 1'b1) begin failures++; $display("FAIL temt_drained got %b want 1", temt); end
    endtask

    task automatic test_fifo_clr();
        int n;
        n = (model_depth() >= 2) ? 2 : 1;
        for (int i = 0; i < n; i++) cyc(1, 8'(8'h60 + i), 0, 0, 0, 0, 0);
        cyc(1, 8'h77, 1, 0, 0, 1, 0);
        checks++; if (tx_level !== 7'd0) begin failures++; $display("FAIL clr_level got %0d want 0", tx_level); end
        checks++; if (thre_int !== 1'b1) begin failures++; $display("FAIL clr_thre_int got %b want 1", thre_int); end
        checks++; if (tx_overrun !== 1'b0) begin failures++; $display("FAIL clr_overrun got %b want 0", tx_overrun); end
        cyc(0, 8'h00, 0, 0, 0, 1, 0);
        checks++; if (thre_int !== 1'b0) begin failures++; $display("FAIL clr_empty_thre_int got %b want 0", thre_int); end
        cyc(0, 8'h00, 0, 1, 1, 0, 0);
    endtask

    task automatic test_utrst();
        int n;
        fifo_en = 1'b1;
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        n = (model_depth() >= 3) ? 3 : model_depth();
        for (int i = 0; i < n; i++) cyc(1, 8'(8'h80 + i), 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        cyc(1, 8'h90, 0, 0, 0, 0, 0);
        checks++; if (tx_level !== 7'(n)) begin failures++; $display("FAIL utrst_pre_level got %0d want %0d", tx_level, n); end
        cyc(0, 8'h00, 0, 0, 0, 0, 1);
        checks++; if (tx_level !== 7'd0) begin failures++; $display("FAIL utrst_level got %0d want 0", tx_level); end
        checks++; if (thre !== 1'b1) begin failures++; $display("FAIL utrst_thre got %b want 1", thre); end
        checks++; if (temt !== 1'b1) begin failures++; $display("FAIL utrst_temt got %b want 1", temt); end
        checks++; if (thre_int !== 1'b1) begin failures++; $display("FAIL utrst_thre_int got %b want 1", thre_int); end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo_full();
        fifo_en = 1'b1;
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0, 0, 0);
        checks++; if (tx_level !== 7'd16) begin failures++; $display("FAIL full_level got %0d want 16", tx_level); end
        checks++; if (tx_overrun !== 1'b0) begin failures++; $display("FAIL full_no_overrun got %b want 0", tx_overrun); end
        cyc(1, 8'h10, 0, 0, 0, 0, 0);
        checks++; if (tx_overrun !== 1'b1) begin failures++; $display("FAIL full_overrun got %b want 1", tx_overrun); end
        checks++; if (tx_level !== 7'd16) begin failures++; $display("FAIL full_overrun_level got %0d want 16", tx_level); end
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        checks++; if (tx_overrun !== 1'b0) begin failures++; $display("FAIL full_overrun_once got %b want 0", tx_overrun); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (tx_data !== 8'(i)) begin failures++; $display("FAIL full_pop_data[%0d] got %h want %h", i, tx_data, 8'(i)); end
            cyc(0, 8'h00, 1, 0, 0, 0, 0);
        end
        checks++; if (thre_int !== 1'b1) begin failures++; $display("FAIL full_drain_thre_int got %b want 1", thre_int); end
        cyc(0, 8'h00, 0, 1, 1, 0, 0);
    endtask

    task automatic test_full_wr_pop();
        logic [7:0] exp_bytes[$];
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_bytes.push_back(b);
            cyc(1, b, 0, 0, 0, 0, 0);
        end
        cyc(1, 8'h55, 1, 0, 0, 0, 0);
        void'(exp_bytes.pop_front());
        exp_bytes.push_back(8'h55);
        checks++; if (tx_level !== 7'd16) begin failures++; $display("FAIL wrpop_level got %0d want 16", tx_level); end
        checks++; if (tx_overrun !== 1'b0) begin failures++; $display("FAIL wrpop_overrun got %b want 0", tx_overrun); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (tx_data !== exp_bytes[i]) begin failures++; $display("FAIL wrpop_data[%0d] got %h want %h", i, tx_data, exp_bytes[i]); end
            cyc(0, 8'h00, 1, 0, 0, 0, 0);
        end
        cyc(0, 8'h00, 0, 1, 1, 0, 0);
    endtask
`endif

    task automatic test_random();
        int r;
        logic [7:0] exp_data;
        for (int c = 0; c < 600; c++) begin
            r = int'($urandom_range(0, 99));
            if (r == 0) fifo_en = ~fifo_en;
            cyc($urandom_range(0, 99) < 50, 8'($urandom_range(0, 255)),
                $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 2);
            exp_data = (mq.size() > 0) ? mq[0] : 8'h00;
            checks++; if (thre !== (mq.size() == 0)) begin failures++; $display("FAIL rnd_thre c=%0d got %b want %b", c, thre, mq.size() == 0); end
            checks++; if (tx_data !== exp_data) begin failures++; $display("FAIL rnd_tx_data c=%0d got %h want %h", c, tx_data, exp_data); end
            checks++; if (tx_level !== 7'(mq.size())) begin failures++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, tx_level, mq.size()); end
            checks++; if (temt !== ((mq.size() == 0) && !m_busy)) begin failures++; $display("FAIL rnd_temt c=%0d got %b want %b", c, temt, (mq.size() == 0) && !m_busy); end
            checks++; if (tx_overrun !== m_ov) begin failures++; $display("FAIL rnd_overrun c=%0d got %b want %b", c, tx_overrun, m_ov); end
            checks++; if (thre_int !== m_ti) begin failures++; $display("FAIL rnd_thre_int c=%0d got %b want %b", c, thre_int, m_ti); end
        end
    endtask

    task automatic test_async_reset();
        fifo_en = 1'b0;
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        cyc(1, 8'hC3, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        cyc(1, 8'hC4, 0, 0, 0, 0, 0);
        #2;
        presetn = 1'b0;
        #1;
        checks++; if (thre !== 1'b1) begin failures++; $display("FAIL areset_thre got %b want 1", thre); end
        checks++; if (temt !== 1'b1) begin failures++; $display("FAIL areset_temt got %b want 1", temt); end
        checks++; if (tx_level !== 7'd0) begin failures++; $display("FAIL areset_level got %0d want 0", tx_level); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL areset_tx_data got %h want 00", tx_data); end
        checks++; if (tx_overrun !== 1'b0) begin failures++; $display("FAIL areset_overrun got %b want 0", tx_overrun); end
        checks++; if (thre_int !== 1'b0) begin failures++; $display("FAIL areset_thre_int got %b want 0", thre_int); end
        model_reset();
        #3;
        presetn = 1'b1;
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        checks++; if (temt !== 1'b1) begin failures++; $display("FAIL areset_release_temt got %b want 1", temt); end
    endtask

    initial begin
        test_reset();
        test_thr_mode();
        test_temt();
        test_fifo_clr();
        test_utrst();
`ifdef UART_TX_FIFO_EN
        test_fifo_full();
        test_full_wr_pop();
`endif
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, transmit FIFO depth in entries; power of two, 2..64.
REQ-002 pclk  input  1  sole clock; all state changes on its rising edge.
REQ-003 presetn  input  1  reset, asynchronous, active-low.
REQ-004 utrst  input  1  synchronous transmitter soft reset, active-high.
REQ-005 thr_wr  input  1  one-cycle write strobe to the transmit holding register or FIFO.
REQ-006 wdata  input  8  write data, sampled when thr_wr=1.
REQ-007 fifo_en  input  1  1 selects FIFO mode; 0 selects single-entry THR mode.
REQ-008 tx_fifo_clr  input  1  synchronous FIFO flush, one-cycle pulse.
REQ-009 tsr_load  input  1  transmitter shift register load pulse; pops the head entry.
REQ-010 transmit_edge  input  1  baud-tick strobe from the transmit clock divider.
REQ-011 shift_cnt_eq  input  1  transmitter frame-complete compare.
REQ-012 thre  output  1  holding/FIFO empty; 1 means no byte is pending for the transmitter.
REQ-013 tx_data  output  8  head-of-queue byte presented to the transmitter.
REQ-014 temt  output  1  transmitter empty: queue empty and no frame in flight.
REQ-015 tx_level  output  7  number of queued bytes.
REQ-016 tx_overrun  output  1  one-cycle pulse when a write is dropped.
REQ-017 thre_int  output  1  one-cycle pulse on every 0->1 transition of thre.

Function
REQ-018 The queue SHALL be a circular buffer with write pointer, read pointer and count; pointers SHALL wrap modulo the effective depth.
REQ-019 The effective depth SHALL be FIFO_DEPTH when fifo_en=1 and 1 when fifo_en=0.
REQ-020 A thr_wr when count < effective depth SHALL enqueue wdata, so the byte appears on tx_data and thre=0 the following cycle.
REQ-021 A thr_wr when count = effective depth and no pop in the same cycle SHALL be dropped and SHALL pulse tx_overrun for one cycle.
REQ-022 A thr_wr and a tsr_load in the same cycle while full SHALL both take effect, leaving count unchanged.
REQ-023 A tsr_load while count=0 SHALL be ignored and leave all state unchanged.
REQ-024 tx_data SHALL be the entry at the read pointer, registered or combinational from storage, and SHALL be stable whenever thre=0 until tsr_load.
REQ-025 thre SHALL equal (count==0).
REQ-026 tx_level SHALL equal count, saturating at FIFO_DEPTH.
REQ-027 The frame-tracking FSM SHALL have two states:
- IDLE: initial state; tsr_load -> BUSY.
- BUSY: transmit_edge & shift_cnt_eq & !tsr_load -> IDLE; tsr_load -> BUSY, back-to-back frames.
REQ-028 temt SHALL equal thre & (state==IDLE).
REQ-029 tx_fifo_clr SHALL zero the pointers and count next cycle, SHALL not affect the FSM, and SHALL take priority over a same-cycle thr_wr or tsr_load.
REQ-030 A change of fifo_en SHALL flush the queue as for tx_fifo_clr.
REQ-031 utrst SHALL flush the queue and force the FSM to IDLE next cycle, taking priority over all other inputs.
REQ-032 thre_int SHALL pulse in the cycle after thre rises; a flush of a non-empty queue SHALL also pulse it.

Reset
REQ-033 On presetn=0 the block SHALL asynchronously set:
- pointers and count = 0
- FSM = IDLE
- thre = 1, temt = 1
- tx_level = 0, tx_overrun = 0, thre_int = 0
- tx_data = 8'h00
REQ-034 Storage contents SHALL not require reset, but tx_data SHALL read 8'h00 while count=0.

Configuration
REQ-035 Macro UART_TX_FIFO_EN: when defined, FIFO storage of FIFO_DEPTH entries SHALL be built and REQ-019 applies.
REQ-036 When UART_TX_FIFO_EN is undefined, only the single-entry THR SHALL be built, fifo_en SHALL be ignored and treated as 0, and tx_level SHALL be 0 or 1.

Verification
REQ-037 Write 8'hA5 with fifo_en=0 -> next cycle thre=0, tx_data=8'hA5; tsr_load -> thre=1 and thre_int pulses once.
REQ-038 fifo_en=1, write 16 bytes 8'h00..8'h0F, then a 17th byte -> tx_level=16 and tx_overrun pulses once; 16 pops -> tx_data sequence 8'h00..8'h0F.
REQ-039 Full queue, simultaneous thr_wr(8'h55) and tsr_load -> tx_level stays 16, no overrun, and 8'h55 is the last byte popped.
REQ-040 tsr_load, then transmit_edge & shift_cnt_eq with the queue empty -> temt=1 the next cycle; with the queue non-empty -> temt stays 0.
REQ-041 3 bytes queued with FSM=BUSY, assert utrst -> next cycle tx_level=0, thre=1, temt=1, and thre_int pulses.
REQ-042 Assert presetn=0 mid-frame -> all outputs at REQ-033 values immediately, without waiting for a pclk edge.
